// File: rtl/rr_arbiter.sv
// N-requester round-robin arbiter with registered one-hot grant, owner index and
// an optional hold limit that forces rotation while other agents are waiting.
module rr_arbiter #(
   parameter int N        = 4,
   parameter int MAX_HOLD = 0,
   parameter int HOLD_W   = 8,
   localparam int ID_W    = (N > 1) ? $clog2(N) : 1
) (
   input  logic            clk,
   input  logic            rest,
   input  logic [N-1:0]    req,
   output logic [N-1:0]    gnt,
   output logic [ID_W-1:0] gnt_id,
   output logic            busy
);

   typedef enum logic {IDLE, OWNED} state_t;

   localparam logic [N-1:0]      ONE       = N'(1);
   localparam logic [HOLD_W-1:0] HOLD_LAST = HOLD_W'(MAX_HOLD > 0 ? MAX_HOLD - 1 : 0);

   state_t            state;
   logic [ID_W-1:0]   last;
   logic [HOLD_W-1:0] hold_cnt;

   logic [N-1:0]      cand;
   logic [2*N-1:0]    dbl;
   logic [N-1:0]      rot;
   logic              found;
   logic              owner_held;
   logic              take;
   logic              release_gnt;
   logic              at_limit;
   logic [ID_W-1:0]   win;
   int                start_i;
   int                off;
   int                win_i;

   // The current owner is never a candidate, so a held request can only be
   // displaced by someone else and a dropped one simply hands off.
   always_comb begin
      cand       = req & ~gnt;
      owner_held = |(req & gnt);
      start_i    = (int'(last) == N - 1) ? 0 : int'(last) + 1;
      dbl        = {cand, cand} >> start_i;
      rot        = dbl[N-1:0];
      found      = 1'b0;
      off        = 0;
      for (int i = 0; i < N; i++) begin
         if (!found && rot[i]) begin
            found = 1'b1;
            off   = i;
         end
      end
      win_i = start_i + off;
      if (win_i >= N) win_i = win_i - N;
      win = ID_W'(win_i);

      at_limit    = (MAX_HOLD != 0) && (hold_cnt == HOLD_LAST);
      take        = found && (state == IDLE || !owner_held || at_limit);
      release_gnt = (state == OWNED) && !owner_held && !found;
   end

   always_ff @(posedge clk or posedge rest) begin
      if (rest) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         hold_cnt <= '0;
         last     <= ID_W'(N - 1);
      end else if (take) begin
         state    <= OWNED;
         gnt      <= ONE << win;
         gnt_id   <= win;
         busy     <= 1'b1;
         hold_cnt <= '0;
         last     <= win;
      end else if (release_gnt) begin
         state    <= IDLE;
         gnt      <= '0;
         gnt_id   <= '0;
         busy     <= 1'b0;
         hold_cnt <= '0;
      end else if (state == OWNED && MAX_HOLD != 0 && !at_limit) begin
         // Saturates at the limit when nobody else is asking.
         hold_cnt <= hold_cnt + 1'b1;
      end
   end

endmodule

// File: doc/rr_arbiter.md
Name: rr_arbiter

Overview:
Parametrised N-requester round-robin arbiter. It is the multi-agent successor of the two-agent request/grant arbiter. A grant is held while the owner keeps its request high, with an optional hold limit that forces rotation. Grants are one-hot and registered; a binary owner index is provided for downstream muxes. It sits between N bus agents and a single shared resource.

Parameters:
N, 4, number of requesters; legal range 2..32.
MAX_HOLD, 0, maximum consecutive grant cycles before forced rotation; 0 = unlimited (hold until release).
HOLD_W, 8, width of the hold counter; MAX_HOLD must be < 2**HOLD_W.
(localparam ID_W = clog2(N), minimum 1.)

Ports:
clk  input  1  single clock; all logic is on its rising edge.
rest  input  1  asynchronous, active-high reset.
req  input  N  per-agent request, level-sensitive; bit i belongs to agent i.
gnt  output  N  one-hot grant, registered; all-zero when idle.
gnt_id  output  ID_W  index of the current owner; 0 when idle.
busy  output  1  high when any gnt bit is high.

Behaviour:
- Interface: one clock (clk); reset is asynchronous and active-high (rest).
- Reset:
  - rest=1 immediately forces gnt=0, gnt_id=0, busy=0, state=IDLE, hold_cnt=0 and last=N-1, so agent 0 has top priority first.
  - Release of rest is synchronous to clk.
- States: IDLE (no owner) and OWNED (one owner; gnt[owner]=1).
- Priority search: starting at index (last+1) mod N, ascending, wrapping at N-1 to 0. The first set req bit wins. last is updated to the winner on each grant.
- IDLE:
  - req!=0 sampled at edge k: OWNED after edge k; gnt[winner]=1; hold_cnt=0.
  - Latency is 1 cycle from the req sample to the visible grant.
  - req==0: stay in IDLE.
- OWNED, owner request dropped (req[owner]=0 at edge k):
  - Any other req set: direct handoff at edge k to the next winner, searched from owner+1. No idle cycle; hold_cnt=0.
  - No other req set: go to IDLE at edge k; gnt=0.
- OWNED, owner request held, MAX_HOLD=0: grant is held indefinitely.
- OWNED, owner request held, MAX_HOLD>0:
  - hold_cnt increments each cycle while owned.
  - When hold_cnt==MAX_HOLD-1 and another req is set at edge k: preempt at edge k. Grant moves to the next winner (searched from owner+1, excluding owner); hold_cnt=0.
  - The preempted agent's still-high req re-enters rotation normally.
  - If no other req is set: owner keeps the grant and hold_cnt saturates at MAX_HOLD-1.
- Invariants:
  - gnt is always one-hot or zero.
  - gnt_id equals the index of the set gnt bit.
  - busy == |gnt.
  - No grant is issued to an agent whose req was 0 at the deciding edge.
- Fairness: with all N requests continuously high and MAX_HOLD=M, each agent receives exactly M consecutive cycles in order 0,1,..,N-1,0,...
- Starvation bound (MAX_HOLD>0): a requester waits at most (N-1)*MAX_HOLD cycles for a grant.
- Reset mid-grant: the grant drops asynchronously. After release, priority restarts at agent 0 regardless of the prior owner.

Test Plan:
- Reset: hold rest=1 with req=4'b1111 -> gnt=0, gnt_id=0, busy=0 throughout; release, then first grant after next edge is gnt=4'b0001.
- Single requester, N=4, MAX_HOLD=0: req=4'b0100 for 5 cycles then 0 -> gnt=4'b0100, gnt_id=2 from the cycle after assert for 5 cycles; gnt=0 one cycle after drop.
- Round-robin handoff: req=4'b1011; each owner drops after 2 grant cycles then re-raises -> grant order 0,1,3,0 with no idle cycle between owners.
- Hold limit, N=4, MAX_HOLD=3, req=4'b1111 held -> gnt rotates 0001,0010,0100,1000,0001, each held exactly 3 cycles; busy stays 1.
- Saturation: MAX_HOLD=3, only req[1] high for 10 cycles -> gnt=4'b0010 for all 10 cycles with no gap.
- Async reset mid-grant: while gnt=4'b1000, pulse rest=1 between edges -> gnt=0 within the same cycle. After release with req=4'b1001 -> gnt=4'b0001 (priority restarted).
- N=2 build: req=2'b11 simultaneous from IDLE -> gnt=2'b01 first; after agent 0 releases -> gnt=2'b10 with gnt_id=1.
